// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types for the fetch/data memory port arbiter.
//   - arb_owner_e  : which port owns the read response due next cycle.
//   - mem_req_type : the single access presented to the unified memory.
//   The struct is sized by MEM_ADDR_W / MEM_DATA_W below; the arbiter's
//   ADDR_W / DATA_W parameters default to these and must match them.
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_e;

    typedef struct packed {
        logic                  en;
        logic                  we;
        logic [MEM_BE_W-1:0]   be;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_type;

endpackage

// File: rtl/mem_arb_stats.sv
// ---------------------------------------------------------------------------
// mem_arb_stats
//   Two free-running 32-bit event counters for the arbiter. Both clear on
//   reset and wrap modulo 2^32. Only instantiated when ARB_STATS_EN is
//   defined in the build.
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   i_conflict          : both ports requested this cycle
//   i_forced            : fetch granted by the starvation guard this cycle
//   o_conflicts         : number of conflict cycles seen
//   o_fetch_forced      : number of starvation-guard fetch grants
// ---------------------------------------------------------------------------
module mem_arb_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_conflict,
    input  logic        i_forced,
    output logic [31:0] o_conflicts,
    output logic [31:0] o_fetch_forced
);

    logic [31:0] r_conflicts;
    logic [31:0] r_fetch_forced;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflicts    <= '0;
            r_fetch_forced <= '0;
        end else begin
            if (i_conflict) r_conflicts    <= r_conflicts + 32'd1;
            if (i_forced)   r_fetch_forced <= r_fetch_forced + 32'd1;
        end
    end

    assign o_conflicts    = r_conflicts;
    assign o_fetch_forced = r_fetch_forced;

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port, synchronous-read memory between instruction
//   fetch (if_*) and load/store (d_*). The access is issued to the memory in
//   the grant cycle; read data is steered back to the owning port in the
//   following cycle. Data has priority, but after MAX_DATA_STREAK
//   consecutive data grants with fetch waiting, fetch is granted once.
//
//   Handshake: a port raises *_req with its command and holds both stable
//   until it sees *_gnt high in the same cycle; the access is issued in that
//   cycle. A read answers with *_rvalid exactly one cycle later. Stores
//   complete at the grant and produce no rvalid.
//
// Ports
//   clk, reset                     : clock, synchronous active-high reset
//   if_req/if_addr                 : fetch read request
//   if_gnt/if_rvalid/if_rdata      : fetch grant and response
//   d_req/d_we/d_be/d_addr/d_wdata : data request (load or store)
//   d_gnt/d_rvalid/d_rdata         : data grant and load response
//   mem_en/we/be/addr/wdata        : access to the unified memory
//   mem_rdata                      : memory read data, 1 cycle after read
//   stat_conflicts/stat_fetch_forced (ARB_STATS_EN only) : event counters
//
// Build option: define ARB_STATS_EN to add the statistics counters.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W          = MEM_ADDR_W,
    parameter int DATA_W          = MEM_DATA_W,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
`ifdef ARB_STATS_EN
    output logic [31:0]         stat_conflicts,
    output logic [31:0]         stat_fetch_forced,
`endif
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    // Consecutive data grants while fetch has been waiting.
    logic [STREAK_W-1:0] r_streak;
    arb_owner_e          r_owner;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic        w_both;
    logic        w_fetch_turn;
    logic        w_if_gnt;
    logic        w_d_gnt;
    logic        w_if_rvalid;
    logic        w_d_rvalid;
    mem_req_type w_mem_req;

    // ---------------- grant ----------------
    always_comb begin
        w_both       = if_req && d_req;
        w_fetch_turn = (r_streak >= STREAK_MAX);
        w_if_gnt     = 1'b0;
        w_d_gnt      = 1'b0;
        // Nothing is issued while reset is held.
        if (!reset) begin
            if (w_both) begin
                if (w_fetch_turn) w_if_gnt = 1'b1;
                else              w_d_gnt  = 1'b1;
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end else if (d_req) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    assign if_gnt = w_if_gnt;
    assign d_gnt  = w_d_gnt;

    // The streak only counts data wins over a waiting fetch; it saturates
    // because a data grant under conflict only happens below the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= '0;
        end else if (w_if_gnt || !if_req) begin
            r_streak <= '0;
        end else if (w_d_gnt && (r_streak != STREAK_MAX)) begin
            r_streak <= r_streak + STREAK_W'(1);
        end
    end

    // ---------------- memory request mux ----------------
    always_comb begin
        w_mem_req = '0;
        if (w_if_gnt) begin
            w_mem_req.en   = 1'b1;
            w_mem_req.we   = 1'b0;
            w_mem_req.be   = '1;
            w_mem_req.addr = if_addr;
        end else if (w_d_gnt) begin
            w_mem_req.en    = 1'b1;
            w_mem_req.we    = d_we;
            w_mem_req.be    = d_be;
            w_mem_req.addr  = d_addr;
            w_mem_req.wdata = d_wdata;
        end
    end

    assign mem_en    = w_mem_req.en;
    assign mem_we    = w_mem_req.we;
    assign mem_be    = w_mem_req.be;
    assign mem_addr  = w_mem_req.addr;
    assign mem_wdata = w_mem_req.wdata;

    // ---------------- response routing ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= OWN_NONE;
        end else if (w_if_gnt) begin
            r_owner <= OWN_IF;
        end else if (w_d_gnt && !d_we) begin
            r_owner <= OWN_D;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    // A read issued just before reset is dropped: rvalid is masked while
    // reset is high, and the owner is cleared at the same edge.
    assign w_if_rvalid = !reset && (r_owner == OWN_IF);
    assign w_d_rvalid  = !reset && (r_owner == OWN_D);

    // Hold registers keep each port's last word while the other port reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_if_rvalid) r_if_rdata <= mem_rdata;
            if (w_d_rvalid)  r_d_rdata  <= mem_rdata;
        end
    end

    assign if_rvalid = w_if_rvalid;
    assign d_rvalid  = w_d_rvalid;
    assign if_rdata  = w_if_rvalid ? mem_rdata : r_if_rdata;
    assign d_rdata   = w_d_rvalid  ? mem_rdata : r_d_rdata;

    // ---------------- statistics ----------------
`ifdef ARB_STATS_EN
    logic w_forced;
    assign w_forced = w_both && w_if_gnt;

    mem_arb_stats u_stats (
        .clk           (clk),
        .reset         (reset),
        .i_conflict    (w_both),
        .i_forced      (w_forced),
        .o_conflicts   (stat_conflicts),
        .o_fetch_forced(stat_fetch_forced)
    );
`endif

    // ---------------- protocol checks ----------------
    // The arbiter does not buffer; a request must stay up until granted.
    a_if_req_held: assert property (@(posedge clk) disable iff (reset)
        (if_req && !if_gnt) |=> if_req);
    a_d_req_held: assert property (@(posedge clk) disable iff (reset)
        (d_req && !d_gnt) |=> d_req);
    a_one_gnt: assert property (@(posedge clk) !(if_gnt && d_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int MAX       = 4;
  localparam int MEM_WORDS = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en, mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
  logic [31:0]       stat_conflicts, stat_fetch_forced;
`endif

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_STREAK(MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef ARB_STATS_EN
    .stat_conflicts(stat_conflicts), .stat_fetch_forced(stat_fetch_forced),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- program memory (environment) ----------------
  logic [DATA_W-1:0] mem_arr [MEM_WORDS];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < BE_W; b++)
          if (mem_be[b]) mem_arr[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem_arr[mem_addr[9:2]];
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];
  logic [DATA_W-1:0] if_exp_q[$];
  logic [DATA_W-1:0] d_exp_q[$];
  logic [DATA_W-1:0] m_if_last, m_d_last;
  int                m_streak;
  int unsigned       m_conf, m_forced;
  bit                g_if, g_d;
  logic              obs_if_gnt, obs_d_gnt;
  logic [DATA_W-1:0] obs_d_load;
  int                n_checks, n_fail;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // One clock cycle: predict and compare at the negedge, advance the model,
  // then return 1 time unit after the posedge so the caller can drive inputs.
  task automatic cycle();
    bit e_if, e_d, e_if_v, e_d_v;
    logic [DATA_W-1:0] e_data;
    @(negedge clk);
    e_if = 1'b0;
    e_d  = 1'b0;
    if (!reset) begin
      if (if_req && d_req) begin
        // data wins until it has won MAX times in a row over waiting fetch
        if (m_streak >= MAX) e_if = 1'b1;
        else                 e_d  = 1'b1;
      end else begin
        e_if = if_req;
        e_d  = d_req;
      end
    end
    obs_if_gnt = if_gnt;
    obs_d_gnt  = d_gnt;

    n_checks++;
    if (if_gnt !== e_if) begin n_fail++; $display("FAIL if_gnt t=%0t got %b want %b", $time, if_gnt, e_if); end
    n_checks++;
    if (d_gnt !== e_d) begin n_fail++; $display("FAIL d_gnt t=%0t got %b want %b", $time, d_gnt, e_d); end
    n_checks++;
    if (mem_en !== (e_if | e_d)) begin n_fail++; $display("FAIL mem_en t=%0t got %b want %b", $time, mem_en, e_if | e_d); end
    if (e_if) begin
      n_checks++;
      if (mem_we !== 1'b0 || mem_be !== 4'hF || mem_addr !== if_addr) begin
        n_fail++;
        $display("FAIL fetch_access t=%0t got we=%b be=%h addr=%h want we=0 be=f addr=%h", $time, mem_we, mem_be, mem_addr, if_addr);
      end
    end
    if (e_d) begin
      n_checks++;
      if (mem_we !== d_we || mem_be !== d_be || mem_addr !== d_addr || (d_we && mem_wdata !== d_wdata)) begin
        n_fail++;
        $display("FAIL data_access t=%0t got we=%b be=%h addr=%h wd=%h want we=%b be=%h addr=%h wd=%h",
                 $time, mem_we, mem_be, mem_addr, mem_wdata, d_we, d_be, d_addr, d_wdata);
      end
    end

    e_if_v = !reset && (if_exp_q.size() > 0);
    n_checks++;
    if (if_rvalid !== e_if_v) begin n_fail++; $display("FAIL if_rvalid t=%0t got %b want %b", $time, if_rvalid, e_if_v); end
    if (e_if_v) begin
      e_data = if_exp_q.pop_front();
      m_if_last = e_data;
    end else begin
      e_data = m_if_last;
    end
    n_checks++;
    if (if_rdata !== e_data) begin n_fail++; $display("FAIL if_rdata t=%0t got %h want %h", $time, if_rdata, e_data); end

    e_d_v = !reset && (d_exp_q.size() > 0);
    n_checks++;
    if (d_rvalid !== e_d_v) begin n_fail++; $display("FAIL d_rvalid t=%0t got %b want %b", $time, d_rvalid, e_d_v); end
    if (e_d_v) begin
      e_data = d_exp_q.pop_front();
      m_d_last = e_data;
      obs_d_load = d_rdata;
    end else begin
      e_data = m_d_last;
    end
    n_checks++;
    if (d_rdata !== e_data) begin n_fail++; $display("FAIL d_rdata t=%0t got %h want %h", $time, d_rdata, e_data); end

`ifdef ARB_STATS_EN
    n_checks++;
    if (stat_conflicts !== m_conf) begin n_fail++; $display("FAIL stat_conflicts t=%0t got %0d want %0d", $time, stat_conflicts, m_conf); end
    n_checks++;
    if (stat_fetch_forced !== m_forced) begin n_fail++; $display("FAIL stat_fetch_forced t=%0t got %0d want %0d", $time, stat_fetch_forced, m_forced); end
`endif

    if (reset) begin
      if_exp_q.delete();
      d_exp_q.delete();
      m_if_last = '0;
      m_d_last  = '0;
      m_streak  = 0;
      m_conf    = 0;
      m_forced  = 0;
    end else begin
      if (if_req && d_req) m_conf++;
      if (e_if && d_req) m_forced++;
      if (e_if) if_exp_q.push_back(ref_mem[if_addr[9:2]]);
      if (e_d) begin
        if (d_we) ref_mem[d_addr[9:2]] = merge(ref_mem[d_addr[9:2]], d_wdata, d_be);
        else      d_exp_q.push_back(ref_mem[d_addr[9:2]]);
      end
      if (e_if || !if_req) m_streak = 0;
      else if (e_d)        m_streak++;
    end
    g_if = e_if;
    g_d  = e_d;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic drain();
    int k;
    k = 0;
    if (g_if) if_req = 1'b0;
    if (g_d)  d_req  = 1'b0;
    while ((if_req || d_req) && k < 20) begin
      cycle();
      k++;
      if (g_if) if_req = 1'b0;
      if (g_d)  d_req  = 1'b0;
    end
    n_checks++;
    if (if_req || d_req) begin
      n_fail++;
      $display("FAIL drain_timeout got if_req=%b d_req=%b want both granted", if_req, d_req);
      if_req = 1'b0;
      d_req  = 1'b0;
    end
    cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    d_be = '0; if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (if_gnt !== 1'b0)    begin n_fail++; $display("FAIL reset_if_gnt got %b want 0", if_gnt); end
    n_checks++; if (d_gnt !== 1'b0)     begin n_fail++; $display("FAIL reset_d_gnt got %b want 0", d_gnt); end
    n_checks++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_if_rvalid got %b want 0", if_rvalid); end
    n_checks++; if (d_rvalid !== 1'b0)  begin n_fail++; $display("FAIL reset_d_rvalid got %b want 0", d_rvalid); end
    n_checks++; if (mem_en !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
    n_checks++; if (mem_we !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_checks++; if (mem_be !== 4'h0)    begin n_fail++; $display("FAIL reset_mem_be got %h want 0", mem_be); end
    n_checks++; if (if_rdata !== '0)    begin n_fail++; $display("FAIL reset_if_rdata got %h want 0", if_rdata); end
    n_checks++; if (d_rdata !== '0)     begin n_fail++; $display("FAIL reset_d_rdata got %h want 0", d_rdata); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_fetch_only();
    for (int i = 0; i < 3; i++) begin
      if_req  = 1'b1;
      if_addr = 32'(i * 4);
      cycle();
    end
    if_req = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_load();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
    cycle();
    d_req = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_store_merge();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'hAABBCCDD;
    cycle();
    d_we = 1'b0; d_be = 4'hF;
    cycle();
    d_req = 1'b0;
    obs_d_load = '0;
    cycle();
    n_checks++;
    if (obs_d_load !== 32'h5A00CCDD) begin
      n_fail++;
      $display("FAIL store_merge got %h want 5a00ccdd", obs_d_load);
    end
  endtask

  task automatic test_streak();
    int n_if, n_d;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h80;
    n_if = 0;
    n_d  = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_if_gnt === 1'b1) n_if++;
      if (obs_d_gnt === 1'b1)  n_d++;
      if (g_if) if_addr = if_addr + 32'd4;
      if (g_d)  d_addr  = d_addr + 32'd4;
    end
    n_checks++;
    if (n_if != 2 || n_d != 8) begin
      n_fail++;
      $display("FAIL streak_counts got if=%0d d=%0d want if=2 d=8", n_if, n_d);
    end
`ifdef ARB_STATS_EN
    n_checks++;
    if (stat_fetch_forced !== 32'd2) begin n_fail++; $display("FAIL streak_forced got %0d want 2", stat_fetch_forced); end
    n_checks++;
    if (stat_conflicts !== 32'd10) begin n_fail++; $display("FAIL streak_conflicts got %0d want 10", stat_conflicts); end
`endif
    drain();
  endtask

  task automatic test_reset_midflight();
    if_req = 1'b1; if_addr = 32'h20;
    cycle();
    if_req = 1'b0;
    reset  = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL midflight_if_rvalid got %b want 0", if_rvalid); end
    n_checks++; if (if_rdata !== '0)    begin n_fail++; $display("FAIL midflight_if_rdata got %h want 0", if_rdata); end
    n_checks++; if (d_rdata !== '0)     begin n_fail++; $display("FAIL midflight_d_rdata got %h want 0", d_rdata); end
    cycle();
  endtask

  task automatic test_random();
    g_if = 1'b0;
    g_d  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!if_req || g_if) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if (!d_req || g_d) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_be    = 4'($urandom_range(0, 15));
        d_addr  = 32'($urandom_range(0, 63)) << 2;
        d_wdata = $urandom();
      end
      cycle();
    end
    drain();
    n_checks++;
    if (if_exp_q.size() != 0 || d_exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL unanswered_reads got if=%0d d=%0d want 0 0", if_exp_q.size(), d_exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0; n_fail = 0;
    m_if_last = '0; m_d_last = '0; m_streak = 0; m_conf = 0; m_forced = 0;
    g_if = 1'b0; g_d = 1'b0; obs_d_load = '0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem_arr[i] = 32'h5A00_0000 | 32'(i);
      ref_mem[i] = 32'h5A00_0000 | 32'(i);
    end
    test_reset();
    test_fetch_only();
    test_load();
    test_store_merge();
    test_streak();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
